// File: rtl/ocp_copy_engine.sv
// ocp_copy_engine: OCP initiator that copies a block of 32-bit words from a
// source to a destination address, one read followed by one write per word.
// A response timeout and non-DVA responses abort the copy with a sticky error.
module ocp_copy_engine #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [31:0]          i_src,
  input  logic [31:0]          i_dst,
  input  logic [CNT_WIDTH-1:0] i_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [CNT_WIDTH-1:0] o_remaining,
  output logic [31:0]          o_MAddr,
  output logic [2:0]           o_MCmd,
  output logic [31:0]          o_MData,
  output logic [3:0]           o_MByteEn,
  input  logic                 i_SCmdAccept,
  input  logic [31:0]          i_SData,
  input  logic [1:0]           i_SResp
);

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
  localparam logic [2:0] OCP_CMD_READ  = 3'b010;
  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;

  // The counter only ever holds 0..TIMEOUT-1; reaching TIMEOUT-1 while the
  // response is still NULL means this is the last cycle we are willing to wait.
  localparam int                   TMO_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST  = TMO_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_CMD  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [31:0]            src_r;
  logic [31:0]            dst_r;
  logic [31:0]            src_nxt_s;
  logic [31:0]            dst_nxt_s;
  logic [CNT_WIDTH-1:0]   rem_nxt_s;
  logic                   err_nxt_s;
  logic [TMO_WIDTH-1:0]   tmo_cnt_r;
  logic [TMO_WIDTH-1:0]   tmo_nxt_s;
  logic                   capture_s;
  logic                   unused_addr_lsb_s;

  // Byte-offset bits of the addresses are deliberately dropped (word copies only).
  assign unused_addr_lsb_s = ^{i_src[1:0], i_dst[1:0]};

  // Next-state and datapath update rules for the copy sequencer
  always_comb begin
    state_nxt_s = state_r;
    src_nxt_s   = src_r;
    dst_nxt_s   = dst_r;
    rem_nxt_s   = o_remaining;
    err_nxt_s   = o_err;
    tmo_nxt_s   = tmo_cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          src_nxt_s = {i_src[31:2], 2'b00};
          dst_nxt_s = {i_dst[31:2], 2'b00};
          rem_nxt_s = i_count;
          err_nxt_s = 1'b0;
          if (i_count == {CNT_WIDTH{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RD_CMD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_CMD: begin
        if (i_SCmdAccept) begin
          state_nxt_s = ST_RD_RESP;
          tmo_nxt_s   = {TMO_WIDTH{1'b0}};
        end else begin
          state_nxt_s = ST_RD_CMD;
        end
      end
      ST_RD_RESP: begin
        if (i_SResp == OCP_RESP_NULL) begin
          if (tmo_cnt_r == TMO_LAST) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            tmo_nxt_s = tmo_cnt_r + TMO_WIDTH'(1);
          end
        end else if (i_SResp == OCP_RESP_DVA) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_WR_CMD;
        end else begin
          err_nxt_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end
      end
      ST_WR_CMD: begin
        if (i_SCmdAccept) begin
          state_nxt_s = ST_WR_RESP;
          tmo_nxt_s   = {TMO_WIDTH{1'b0}};
        end else begin
          state_nxt_s = ST_WR_CMD;
        end
      end
      ST_WR_RESP: begin
        if (i_SResp == OCP_RESP_NULL) begin
          if (tmo_cnt_r == TMO_LAST) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            tmo_nxt_s = tmo_cnt_r + TMO_WIDTH'(1);
          end
        end else if (i_SResp == OCP_RESP_DVA) begin
          // Remaining only drops once the write is confirmed, so an aborted
          // word is still reported as outstanding.
          src_nxt_s = src_r + 32'd4;
          dst_nxt_s = dst_r + 32'd4;
          rem_nxt_s = o_remaining - CNT_WIDTH'(1);
          if (o_remaining == CNT_WIDTH'(1)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RD_CMD;
          end
        end else begin
          err_nxt_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered OCP/status outputs, all derived from next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      src_r       <= 32'd0;
      dst_r       <= 32'd0;
      tmo_cnt_r   <= {TMO_WIDTH{1'b0}};
      o_remaining <= {CNT_WIDTH{1'b0}};
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_MCmd      <= OCP_CMD_IDLE;
      o_MAddr     <= 32'd0;
      o_MData     <= 32'd0;
      o_MByteEn   <= 4'hF;
    end else begin
      state_r     <= state_nxt_s;
      src_r       <= src_nxt_s;
      dst_r       <= dst_nxt_s;
      tmo_cnt_r   <= tmo_nxt_s;
      o_remaining <= rem_nxt_s;
      o_err       <= err_nxt_s;
      o_busy      <= (state_nxt_s != ST_IDLE);
      o_done      <= (state_nxt_s == ST_DONE);
      o_MByteEn   <= 4'hF;
      case (state_nxt_s)
        ST_RD_CMD: begin
          o_MCmd  <= OCP_CMD_READ;
          o_MAddr <= src_nxt_s;
        end
        ST_WR_CMD: begin
          o_MCmd  <= OCP_CMD_WRITE;
          o_MAddr <= dst_nxt_s;
        end
        default: begin
          o_MCmd  <= OCP_CMD_IDLE;
        end
      endcase
      if (capture_s) begin
        o_MData <= i_SData;
      end
    end
  end

endmodule

// File: tb/tb_ocp_copy_engine.sv
// tb_ocp_copy_engine: directed and randomized copies against a behavioural
// OCP memory responder; expected timing, status and memory contents come from
// a cycle-count/word-count model of the copy rules.
module tb_ocp_copy_engine;

  localparam int TMO = 8;
  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_WRITE = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_src;
  logic [31:0] i_dst;
  logic [15:0] i_count;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [15:0] o_remaining;
  logic [31:0] o_MAddr;
  logic [2:0]  o_MCmd;
  logic [31:0] o_MData;
  logic [3:0]  o_MByteEn;
  logic        i_SCmdAccept;
  logic [31:0] i_SData;
  logic [1:0]  i_SResp;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural memory and responder state
  logic [31:0] mem [logic [31:0]];
  logic [31:0] src_data [16];
  bit          pend;
  int          pend_wait;
  logic [1:0]  pend_resp;
  logic [31:0] pend_data;
  int          stall_left;

  ocp_copy_engine #(.CNT_WIDTH(16), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_src        (i_src),
    .i_dst        (i_dst),
    .i_count      (i_count),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_remaining  (o_remaining),
    .o_MAddr      (o_MAddr),
    .o_MCmd       (o_MCmd),
    .o_MData      (o_MData),
    .o_MByteEn    (o_MByteEn),
    .i_SCmdAccept (i_SCmdAccept),
    .i_SData      (i_SData),
    .i_SResp      (i_SResp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/MCmd"},      64'(o_MCmd),      64'(CMD_IDLE));
    check({tag, "/MAddr"},     64'(o_MAddr),     64'd0);
    check({tag, "/MData"},     64'(o_MData),     64'd0);
    check({tag, "/MByteEn"},   64'(o_MByteEn),   64'hF);
    check({tag, "/busy"},      64'(o_busy),      64'd0);
    check({tag, "/done"},      64'(o_done),      64'd0);
    check({tag, "/err"},       64'(o_err),       64'd0);
    check({tag, "/remaining"}, 64'(o_remaining), 64'd0);
  endtask

  // One copy: model the outcome, drive start, act as the responder each cycle,
  // then compare timing, status, bus behaviour and memory contents.
  // fail_txn / silent_txn index bus transactions (even = read, odd = write); -1 = none.
  task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int n, input int lat, input int stall, input int fail_txn,
                          input int silent_txn, input bit extra_start, input int rst_cyc);
    logic [31:0] sa, da, a;
    int          exp_done, exp_words, exp_txns, cyc, done_cyc, txn, w;
    logic        exp_err, err_at;
    logic [15:0] exp_rem, rem_at;
    bit          bus_ok, busy_ok;

    sa = {src[31:2], 2'b00};
    da = {dst[31:2], 2'b00};
    if (n == 0) begin
      exp_done = 1; exp_err = 1'b0; exp_words = 0; exp_txns = 0;
    end else if (fail_txn >= 0) begin
      exp_done  = 1 + stall + (fail_txn + 1) * (2 + lat);
      exp_err   = 1'b1; exp_words = fail_txn / 2; exp_txns = fail_txn + 1;
    end else if (silent_txn >= 0) begin
      exp_done  = 1 + stall + silent_txn * (2 + lat) + 1 + TMO;
      exp_err   = 1'b1; exp_words = silent_txn / 2; exp_txns = silent_txn + 1;
    end else begin
      exp_done  = 1 + stall + n * (4 + 2 * lat);
      exp_err   = 1'b0; exp_words = n; exp_txns = 2 * n;
    end
    exp_rem = 16'(n - exp_words);

    for (int i = 0; i < n; i++) begin
      a = da + 32'(4 * i);
      if (mem.exists(a)) mem.delete(a);
    end
    for (int i = 0; i < n; i++) begin
      src_data[i] = $urandom;
      mem[sa + 32'(4 * i)] = src_data[i];
    end

    pend = 1'b0; stall_left = stall; txn = 0; bus_ok = 1'b1; busy_ok = 1'b1;
    done_cyc = -1; err_at = 1'b0; rem_at = 16'd0;

    @(negedge clk);
    i_src = src; i_dst = dst; i_count = 16'(n); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc <= exp_done + 20) begin
      if (rst_cyc > 0 && cyc == rst_cyc) begin
        rst = 1'b1; i_SCmdAccept = 1'b0; i_SResp = RESP_NULL;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (o_done === 1'b1) begin
        done_cyc = cyc; err_at = o_err; rem_at = o_remaining;
      end
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      // response channel: the pending response shows up after its latency
      if (pend && pend_wait == 0) begin
        i_SResp = pend_resp; i_SData = pend_data; pend = 1'b0;
      end else begin
        i_SResp = RESP_NULL; i_SData = $urandom;
        if (pend) pend_wait--;
      end
      // command channel: check the expected command/address, then accept
      i_SCmdAccept = 1'b0;
      if (o_MCmd !== CMD_IDLE) begin
        w = txn / 2;
        if (txn % 2 == 0) begin
          if (o_MCmd !== CMD_READ || o_MAddr !== sa + 32'(4 * w)) bus_ok = 1'b0;
        end else begin
          if (o_MCmd !== CMD_WRITE || o_MAddr !== da + 32'(4 * w)) bus_ok = 1'b0;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          i_SCmdAccept = 1'b1;
          if (txn != silent_txn) begin
            pend = 1'b1; pend_wait = lat;
            pend_resp = (txn == fail_txn) ? RESP_ERR : RESP_DVA;
            pend_data = $urandom;
            if (txn % 2 == 0) begin
              pend_data = mem.exists(o_MAddr) ? mem[o_MAddr] : 32'hBAD0_0000;
            end else if (txn != fail_txn) begin
              mem[o_MAddr] = o_MData;
            end
          end
          txn++;
        end
      end
      if (extra_start && cyc == 3) begin
        i_start = 1'b1; i_src = 32'h00F0_0000; i_dst = 32'h00F8_0000; i_count = 16'd7;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0; i_SCmdAccept = 1'b0; i_SResp = RESP_NULL;

    if (rst_cyc > 0) begin
      check_reset_values({tag, "/after_rst"});
      pend = 1'b0;
      return;
    end

    check({tag, "/done_cycle"}, 64'(done_cyc),  64'(exp_done));
    check({tag, "/err"},        64'(err_at),    64'(exp_err));
    check({tag, "/remaining"},  64'(rem_at),    64'(exp_rem));
    check({tag, "/bus_txns"},   64'(txn),       64'(exp_txns));
    check({tag, "/bus_cmd"},    64'(bus_ok),    64'd1);
    check({tag, "/busy_high"},  64'(busy_ok),   64'd1);
    check({tag, "/done_pulse"}, 64'(o_done),    64'd0);
    check({tag, "/busy_low"},   64'(o_busy),    64'd0);
    check({tag, "/err_sticky"}, 64'(o_err),     64'(exp_err));
    for (int i = 0; i < n; i++) begin
      a = da + 32'(4 * i);
      if (i < exp_words) begin
        check({tag, "/mem"}, 64'(mem.exists(a) ? mem[a] : 32'hDEAD_BEEF), 64'(src_data[i]));
      end else begin
        check({tag, "/untouched"}, 64'(mem.exists(a)), 64'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] rs, rd;
    int          rn, rl, rst_stall, rf;

    rst = 1'b1; i_start = 1'b0; i_src = 32'd0; i_dst = 32'd0; i_count = 16'd0;
    i_SCmdAccept = 1'b0; i_SData = 32'd0; i_SResp = RESP_NULL;
    pend = 1'b0; pend_wait = 0; pend_resp = RESP_NULL; pend_data = 32'd0; stall_left = 0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    run_copy("copy4",      32'h0000_0100, 32'h0000_0200, 4, 0, 0, -1, -1, 1'b0, 0);
    run_copy("zero_count", 32'h0000_0100, 32'h0000_0200, 0, 0, 0, -1, -1, 1'b0, 0);
    run_copy("unaligned",  32'h0000_0103, 32'h0000_0202, 1, 0, 0, -1, -1, 1'b0, 0);
    run_copy("stall5",     32'h0000_0400, 32'h0000_0500, 2, 0, 5, -1, -1, 1'b0, 0);
    run_copy("wr2_error",  32'h0000_0600, 32'h0000_0700, 3, 0, 0, 3, -1, 1'b0, 0);
    run_copy("err_clear",  32'h0000_0800, 32'h0000_0900, 2, 1, 0, -1, -1, 1'b0, 0);
    run_copy("rd_error",   32'h0000_0A00, 32'h0000_0B00, 3, 0, 0, 2, -1, 1'b0, 0);
    run_copy("timeout",    32'h0000_0C00, 32'h0000_0D00, 2, 0, 0, -1, 0, 1'b0, 0);
    run_copy("wr_timeout", 32'h0000_0E00, 32'h0000_0F00, 2, 1, 0, -1, 3, 1'b0, 0);
    run_copy("extra_start",32'h0000_1000, 32'h0000_1100, 3, 1, 0, -1, -1, 1'b1, 0);
    run_copy("addr_wrap",  32'hFFFF_FFF8, 32'h0000_3000, 3, 0, 0, -1, -1, 1'b0, 0);
    run_copy("mid_reset",  32'h0000_1200, 32'h0000_1300, 4, 0, 0, -1, -1, 1'b0, 6);
    run_copy("post_reset", 32'h0000_1400, 32'h0000_1500, 2, 0, 0, -1, -1, 1'b0, 0);

    for (int k = 0; k < 10; k++) begin
      rn = $urandom_range(1, 6);
      rl = $urandom_range(0, 3);
      rst_stall = $urandom_range(0, 3);
      rf = (k % 3 == 2) ? $urandom_range(0, 2 * rn - 1) : -1;
      rs = 32'h0001_0000 + 32'($urandom_range(0, 255) * 64) + 32'($urandom_range(0, 3));
      rd = 32'h0008_0000 + 32'($urandom_range(0, 255) * 64) + 32'($urandom_range(0, 3));
      run_copy("random", rs, rd, rn, rl, rst_stall, rf, -1, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
